// File: rtl/nn_load_ctrl_if.sv
// Stream and memory-bus bundle for nn_load_ctrl.
//   Stream : in_valid, in_data (producer -> controller), in_ready (controller -> producer)
//   Weight : w_addr, w_data, w_sel, w_rw (controller -> weight mem_sys)
//   Input  : x_addr, x_data, x_sel, x_rw (controller -> input mem_sys)
// master = controller side, slave = stream producer / memory side.
interface nn_load_ctrl_if #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2
);
  logic                  in_valid;
  logic                  in_data;
  logic                  in_ready;
  logic [W_ADDR_LEN-1:0] w_addr;
  logic                  w_data;
  logic [W_SEL_LEN-1:0]  w_sel;
  logic [1:0]            w_rw;
  logic [X_ADDR_LEN-1:0] x_addr;
  logic                  x_data;
  logic [X_SEL_LEN-1:0]  x_sel;
  logic [1:0]            x_rw;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output w_addr, w_data, w_sel, w_rw,
    output x_addr, x_data, x_sel, x_rw
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  w_addr, w_data, w_sel, w_rw,
    input  x_addr, x_data, x_sel, x_rw
  );
endinterface

// File: rtl/nn_load_ctrl.sv
// Load/compute sequencer for the binarized NN datapath.
// Takes a 1-bit valid/ready stream, writes w_len bits into each of N_WBANK
// weight banks, then x_len bits into input bank 0, then pulses start_compute
// and waits for compute_done before returning to idle.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load_start     : run request, honoured only when idle
//   w_len, x_len   : bits per weight bank / input bank, sampled on accept
//   bus            : stream handshake plus weight and input write buses
//   start_compute  : one-cycle pulse to compute_module
//   compute_done   : completion from compute_module (level or pulse)
//   busy           : high whenever not idle
//   done           : one-cycle pulse at end of run
//   err            : one-cycle pulse when load_start has a zero length
module nn_load_ctrl #(
  parameter int W_ADDR_LEN = 20,
  parameter int X_ADDR_LEN = 10,
  parameter int W_SEL_LEN  = 2,
  parameter int X_SEL_LEN  = 2,
  parameter int N_WBANK    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [W_ADDR_LEN-1:0] w_len,
  input  logic [X_ADDR_LEN-1:0] x_len,
  nn_load_ctrl_if.master        bus,
  output logic                  start_compute,
  input  logic                  compute_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    START,
    WAIT_DONE
  } state_t;

  localparam logic [W_SEL_LEN-1:0] LAST_BANK = W_SEL_LEN'(N_WBANK - 1);

  state_t                state;
  logic [W_ADDR_LEN-1:0] cnt;
  logic [W_SEL_LEN-1:0]  bank;
  // Terminal counts are latched as length-1 so the beat compare is a plain equality.
  logic [W_ADDR_LEN-1:0] w_last;
  logic [X_ADDR_LEN-1:0] x_last;
  logic                  beat;

  assign bus.in_ready = (state == LOAD_W) || (state == LOAD_X);
  assign beat         = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bank          <= '0;
      w_last        <= '0;
      x_last        <= '0;
      bus.w_addr    <= '0;
      bus.w_data    <= 1'b0;
      bus.w_sel     <= '0;
      bus.w_rw      <= 2'b00;
      bus.x_addr    <= '0;
      bus.x_data    <= 1'b0;
      bus.x_sel     <= '0;
      bus.x_rw      <= 2'b00;
      start_compute <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Strobes and pulses default low; address/select/data hold between beats.
      bus.w_rw      <= 2'b00;
      bus.x_rw      <= 2'b00;
      start_compute <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;

      unique case (state)
        IDLE: begin
          if (load_start) begin
            if ((w_len == '0) || (x_len == '0)) begin
              err <= 1'b1;
            end else begin
              w_last <= w_len - W_ADDR_LEN'(1);
              x_last <= x_len - X_ADDR_LEN'(1);
              cnt    <= '0;
              bank   <= '0;
              busy   <= 1'b1;
              state  <= LOAD_W;
            end
          end
        end

        LOAD_W: begin
          if (beat) begin
            bus.w_addr <= cnt;
            bus.w_data <= bus.in_data;
            bus.w_sel  <= bank;
            bus.w_rw   <= 2'b01;
            if (cnt == w_last) begin
              cnt <= '0;
              if (bank == LAST_BANK) begin
                bank  <= '0;
                state <= LOAD_X;
              end else begin
                bank <= bank + W_SEL_LEN'(1);
              end
            end else begin
              cnt <= cnt + W_ADDR_LEN'(1);
            end
          end
        end

        LOAD_X: begin
          if (beat) begin
            bus.x_addr <= cnt[X_ADDR_LEN-1:0];
            bus.x_data <= bus.in_data;
            bus.x_sel  <= '0;
            bus.x_rw   <= 2'b01;
            if (cnt[X_ADDR_LEN-1:0] == x_last) begin
              // start_compute is raised on the same edge as the last x strobe,
              // so the START state is exactly the pulse cycle.
              cnt           <= '0;
              start_compute <= 1'b1;
              state         <= START;
            end else begin
              cnt <= cnt + W_ADDR_LEN'(1);
            end
          end
        end

        START: begin
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (compute_done) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_load_ctrl.sv
module tb_nn_load_ctrl;
  localparam int WA = 20;
  localparam int XA = 10;
  localparam int WS = 2;
  localparam int XS = 2;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [WA-1:0] w_len;
  logic [XA-1:0] x_len;
  logic          start_compute;
  logic          compute_done;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;

  nn_load_ctrl_if #(.W_ADDR_LEN(WA), .X_ADDR_LEN(XA), .W_SEL_LEN(WS), .X_SEL_LEN(XS)) bus ();

  nn_load_ctrl #(
    .W_ADDR_LEN(WA),
    .X_ADDR_LEN(XA),
    .W_SEL_LEN (WS),
    .X_SEL_LEN (XS),
    .N_WBANK   (NB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .w_len        (w_len),
    .x_len        (x_len),
    .bus          (bus),
    .start_compute(start_compute),
    .compute_done (compute_done),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Concatenation of every DUT output, for all-zero checks.
  function automatic logic [63:0] all_outs();
    return 64'({bus.in_ready, bus.w_addr, bus.w_data, bus.w_sel, bus.w_rw,
                bus.x_addr, bus.x_data, bus.x_sel, bus.x_rw,
                start_compute, busy, done, err});
  endfunction

  // Streams one run. Beat k maps to weight bank k/wl, addr k%wl for the first
  // NB*wl beats, then input addr k-NB*wl. abort_at>0 stops after that many beats.
  task automatic run_stream(input int wl, input int xl, input int mode, input int abort_at);
    int   total;
    int   k;
    int   cyc;
    int   nw;
    int   nx;
    int   exp_sel;
    int   exp_addr;
    int   lw_sel;
    int   lw_addr;
    logic beat;
    logic d;
    logic last;
    total   = NB * wl + xl;
    k       = 0;
    cyc     = 0;
    nw      = 0;
    nx      = 0;
    lw_sel  = -1;
    lw_addr = -1;

    load_start = 1'b1;
    w_len      = WA'(wl);
    x_len      = XA'(xl);
    tick();
    load_start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || bus.w_rw !== 2'b00) begin
      n_err++;
      $display("FAIL run_accept wl=%0d xl=%0d: got busy=%b in_ready=%b done=%b err=%b w_rw=%b, want 1 1 0 0 00",
               wl, xl, busy, bus.in_ready, done, err, bus.w_rw);
    end

    while (k < total && !(abort_at > 0 && k == abort_at)) begin
      if (cyc > 8 * total + 20) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_timeout: got %0d beats after %0d cycles, want %0d", k, cyc, total);
        break;
      end
      case (mode)
        0: begin
          bus.in_valid = 1'b1;
          bus.in_data  = (k % 2 == 0);
        end
        1: begin
          bus.in_valid = (cyc % 2 == 0);
          bus.in_data  = 1'($urandom_range(0, 1));
        end
        default: begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          bus.in_data  = 1'($urandom_range(0, 1));
          compute_done = 1'($urandom_range(0, 1));
        end
      endcase
      beat = bus.in_valid && bus.in_ready;
      d    = bus.in_data;
      tick();
      cyc++;
      if (bus.w_rw === 2'b01) nw++;
      if (bus.x_rw === 2'b01) nx++;

      if (beat) begin
        last = (k == total - 1);
        n_cmp++;
        if (k < NB * wl) begin
          exp_sel  = k / wl;
          exp_addr = k % wl;
          lw_sel   = exp_sel;
          lw_addr  = exp_addr;
          if (bus.w_rw !== 2'b01 || bus.x_rw !== 2'b00 || bus.w_sel !== WS'(exp_sel) ||
              bus.w_addr !== WA'(exp_addr) || bus.w_data !== d || busy !== 1'b1) begin
            n_err++;
            $display("FAIL w_strobe k=%0d: got rw=%b/%b sel=%0d addr=%0d data=%b busy=%b, want rw=01/00 sel=%0d addr=%0d data=%b busy=1",
                     k, bus.w_rw, bus.x_rw, bus.w_sel, bus.w_addr, bus.w_data, busy, exp_sel, exp_addr, d);
          end
        end else begin
          exp_addr = k - NB * wl;
          if (bus.x_rw !== 2'b01 || bus.w_rw !== 2'b00 || bus.x_sel !== '0 ||
              bus.x_addr !== XA'(exp_addr) || bus.x_data !== d || busy !== 1'b1) begin
            n_err++;
            $display("FAIL x_strobe k=%0d: got rw=%b/%b sel=%0d addr=%0d data=%b busy=%b, want rw=00/01 sel=0 addr=%0d data=%b busy=1",
                     k, bus.w_rw, bus.x_rw, bus.x_sel, bus.x_addr, bus.x_data, busy, exp_addr, d);
          end
        end
        n_cmp++;
        if (start_compute !== last || bus.in_ready !== !last) begin
          n_err++;
          $display("FAIL start_align k=%0d: got start_compute=%b in_ready=%b, want %b %b",
                   k, start_compute, bus.in_ready, last, !last);
        end
        k++;
      end else begin
        n_cmp++;
        if (bus.w_rw !== 2'b00 || bus.x_rw !== 2'b00 || busy !== 1'b1 || start_compute !== 1'b0 ||
            (lw_sel >= 0 && (bus.w_sel !== WS'(lw_sel) || bus.w_addr !== WA'(lw_addr)))) begin
          n_err++;
          $display("FAIL gap cyc=%0d: got rw=%b/%b busy=%b start=%b sel=%0d addr=%0d, want rw=00/00 busy=1 start=0 hold sel=%0d addr=%0d",
                   cyc, bus.w_rw, bus.x_rw, busy, start_compute, bus.w_sel, bus.w_addr, lw_sel, lw_addr);
        end
      end
    end
    bus.in_valid = 1'b0;
    compute_done = 1'b0;

    if (abort_at == 0) begin
      n_cmp++;
      if (nw !== NB * wl || nx !== xl) begin
        n_err++;
        $display("FAIL strobe_count wl=%0d xl=%0d: got w=%0d x=%0d, want w=%0d x=%0d", wl, xl, nw, nx, NB * wl, xl);
      end
    end
  endtask

  // Called in the START cycle. Spends n cycles before raising compute_done
  // (the first leaves START); optionally fires an ignored load_start meanwhile.
  task automatic wait_done(input int n, input bit probe);
    for (int i = 0; i < n; i++) begin
      if (probe && i == 1) begin
        load_start = 1'b1;
        w_len      = WA'(1);
        x_len      = XA'(1);
      end
      tick();
      load_start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || start_compute !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.w_rw !== 2'b00 || bus.x_rw !== 2'b00 || err !== 1'b0) begin
        n_err++;
        $display("FAIL wait i=%0d: got busy=%b done=%b start=%b in_ready=%b rw=%b/%b err=%b, want 1 0 0 0 00/00 0",
                 i, busy, done, start_compute, bus.in_ready, bus.w_rw, bus.x_rw, err);
      end
    end
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got done=%b busy=%b in_ready=%b, want 1 0 0", done, busy, bus.in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want 0", all_outs());
    end
  endtask

  task automatic test_err;
    for (int i = 0; i < 2; i++) begin
      load_start = 1'b1;
      w_len      = (i == 0) ? WA'(3) : '0;
      x_len      = (i == 0) ? '0 : XA'(2);
      tick();
      load_start = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL err_pulse case=%0d: got err=%b busy=%b in_ready=%b, want 1 0 0", i, err, busy, bus.in_ready);
      end
      tick();
      n_cmp++;
      if (all_outs() !== '0) begin
        n_err++;
        $display("FAIL err_after case=%0d: got %h, want 0", i, all_outs());
      end
    end
  endtask

  task automatic test_continuous;
    run_stream(3, 2, 0, 0);
    wait_done(5, 1'b0);
  endtask

  task automatic test_toggle_and_back_to_back;
    run_stream(3, 2, 1, 0);
    wait_done(5, 1'b1);
    run_stream(2, 3, 0, 0);
    wait_done(2, 1'b0);
  endtask

  task automatic test_min_len;
    run_stream(1, 1, 0, 0);
    wait_done(1, 1'b0);
  endtask

  task automatic test_abort;
    run_stream(3, 2, 0, 5);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got %h, want 0", all_outs());
    end
    run_stream(2, 1, 0, 0);
    wait_done(1, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      run_stream(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)), 2, 0);
      wait_done(int'($urandom_range(1, 4)), 1'b0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    load_start   = 1'b0;
    w_len        = '0;
    x_len        = '0;
    compute_done = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;

    test_reset();
    test_err();
    test_continuous();
    test_toggle_and_back_to_back();
    test_min_len();
    test_abort();
    test_random();

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, want $finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
